gated_event_counter: RTL and testbench

//  Counts asynchronous detector events (rising edges on i_event) inside each

---
 rtl/gated_event_counter.sv | 138 +++++++++++++
 tb/tb_gated_event_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gated_event_counter.sv
// Counts synchronised detector edges inside each gate window, one result per gate.
// Optional first-hit timer enabled by defining GATE_TDC_EN.
module gated_event_counter #(
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
`ifdef GATE_TDC_EN
  ,
  parameter int TDC_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_gate,
  input  logic              i_event,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DROP_W-1:0] o_drop_cnt,
  output logic              o_busy
`ifdef GATE_TDC_EN
  ,
  output logic [TDC_W-1:0]  o_first
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_ev_s1;
  logic               r_ev_s2;
  logic               r_ev_d;
  logic               r_gate_last;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;

  logic               w_edge;
  logic               w_rise;
  logic               w_fall;
  logic               w_take;

  assign w_edge = r_ev_s2 & ~r_ev_d;
  assign w_rise = i_gate & ~r_gate_last;
  assign w_fall = ~i_gate & r_gate_last;
  assign w_take = ~o_valid | i_ready;
  assign o_busy = (r_state != S_IDLE);

`ifdef GATE_TDC_EN
  logic [TDC_W-1:0]   r_tmr;
  logic [TDC_W-1:0]   r_first;
  logic               r_hit;
`endif

  // Gate history resets high so a gate already open at reset is never seen as a rise.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ev_s1     <= 1'b0;
      r_ev_s2     <= 1'b0;
      r_ev_d      <= 1'b0;
      r_gate_last <= 1'b1;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      o_count     <= '0;
      o_overflow  <= 1'b0;
      o_valid     <= 1'b0;
      o_drop_cnt  <= '0;
`ifdef GATE_TDC_EN
      r_tmr       <= '0;
      r_first     <= '1;
      r_hit       <= 1'b0;
      o_first     <= '0;
`endif
    end else begin
      r_ev_s1     <= i_event;
      r_ev_s2     <= r_ev_s1;
      r_ev_d      <= r_ev_s2;
      r_gate_last <= i_gate;

      if (o_valid && i_ready)
        o_valid <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
`ifdef GATE_TDC_EN
            r_tmr   <= '0;
            r_first <= '1;
            r_hit   <= 1'b0;
`endif
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (w_fall) begin
            r_state <= S_LATCH;
          end else begin
`ifdef GATE_TDC_EN
            if (r_tmr != '1)
              r_tmr <= r_tmr + 1'b1;
            if (w_edge && i_gate && !r_hit) begin
              r_first <= r_tmr;
              r_hit   <= 1'b1;
            end
`endif
            if (w_edge && i_gate) begin
              if (r_cnt == '1)
                r_ovf <= 1'b1;
              else
                r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_LATCH: begin
          if (w_take) begin
            o_count    <= r_cnt;
            o_overflow <= r_ovf;
`ifdef GATE_TDC_EN
            o_first    <= r_first;
`endif
            o_valid    <= 1'b1;
          end else if (o_drop_cnt != '1) begin
            o_drop_cnt <= o_drop_cnt + 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gated_event_counter.sv
// Directed bench for gated_event_counter: default instance plus a CNT_W=4
// instance sharing the same stimulus for the saturation case.
module tb_gated_event_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        gate;
  logic        ev;
  logic        rdy;

  logic [15:0] cnt;
  logic        ovf;
  logic        vld;
  logic [7:0]  drop;
  logic        busy;

  logic [3:0]  cnt4;
  logic        ovf4;
  logic        vld4;
  logic [7:0]  drop4;
  logic        busy4;

`ifdef GATE_TDC_EN
  logic [15:0] first;
  logic [15:0] first4;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gated_event_counter dut (
    .clk        (clk),
    .i_rst      (rst),
    .i_gate     (gate),
    .i_event    (ev),
    .o_count    (cnt),
    .o_overflow (ovf),
    .o_valid    (vld),
    .i_ready    (rdy),
    .o_drop_cnt (drop),
    .o_busy     (busy)
`ifdef GATE_TDC_EN
    ,
    .o_first    (first)
`endif
  );

  gated_event_counter #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .i_rst      (rst),
    .i_gate     (gate),
    .i_event    (ev),
    .o_count    (cnt4),
    .o_overflow (ovf4),
    .o_valid    (vld4),
    .i_ready    (rdy),
    .o_drop_cnt (drop4),
    .o_busy     (busy4)
`ifdef GATE_TDC_EN
    ,
    .o_first    (first4)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      ev = 1'b1;
      tick(4);
      ev = 1'b0;
      tick(2);
    end
  endtask

  task automatic gate_run(input int n);
    gate = 1'b1;
    tick(2);
    pulses(n);
    tick(2);
    gate = 1'b0;
  endtask

  int seen;

  initial begin
    rst  = 1'b1;
    gate = 1'b0;
    ev   = 1'b0;
    rdy  = 1'b1;
    tick(3);
    chk("rst_cnt",  32'(cnt),  32'd0);
    chk("rst_vld",  32'(vld),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    rst = 1'b0;
    tick(2);

    // three events in one gate, two-cycle result latency, then transfer
    gate_run(3);
    tick();
    chk("t1_lat_vld", 32'(vld), 32'd0);
    tick();
    chk("t1_vld",  32'(vld), 32'd1);
    chk("t1_cnt",  32'(cnt), 32'd3);
    chk("t1_ovf",  32'(ovf), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    tick();
    chk("t1_xfer", 32'(vld), 32'd0);
    tick(2);

    // twenty events: narrow counter saturates
    gate_run(20);
    tick(2);
    chk("t2_cnt4", 32'(cnt4), 32'd15);
    chk("t2_ovf4", 32'(ovf4), 32'd1);
    chk("t2_cnt",  32'(cnt),  32'd20);
    chk("t2_ovf",  32'(ovf),  32'd0);
    tick(3);

    // stalled output: second result dropped
    rdy = 1'b0;
    gate_run(2);
    tick(2);
    chk("t3_vld_a", 32'(vld), 32'd1);
    chk("t3_cnt_a", 32'(cnt), 32'd2);
    tick(3);
    gate_run(5);
    tick(2);
    chk("t3_cnt_b", 32'(cnt),  32'd2);
    chk("t3_drop",  32'(drop), 32'd1);
    chk("t3_vld_b", 32'(vld),  32'd1);
    rdy = 1'b1;
    tick();
    chk("t3_xfer", 32'(vld), 32'd0);
    tick(2);

    // level across gate start and edge on the fall cycle are not counted
    ev = 1'b1;
    tick(4);
    gate = 1'b1;
    tick(6);
    ev = 1'b0;
    tick(4);
    ev = 1'b1;
    tick(2);
    gate = 1'b0;
    tick(2);
    chk("t4_vld", 32'(vld), 32'd1);
    chk("t4_cnt", 32'(cnt), 32'd0);
    ev = 1'b0;
    tick(3);

    // reset mid-gate discards the window
    gate = 1'b1;
    tick(2);
    pulses(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_cnt",  32'(cnt),  32'd0);
    chk("t5_ovf",  32'(ovf),  32'd0);
    chk("t5_vld",  32'(vld),  32'd0);
    chk("t5_drop", 32'(drop), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    seen = 0;
    tick(4);
    gate = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (vld || busy) seen++;
    end
    chk("t5_quiet", 32'(seen), 32'd0);
    gate_run(2);
    tick(2);
    chk("t5_vld2", 32'(vld), 32'd1);
    chk("t5_cnt2", 32'(cnt), 32'd2);
    tick(3);

`ifdef GATE_TDC_EN
    // edge lands in the 6th COUNT cycle
    gate = 1'b1;
    tick(4);
    ev = 1'b1;
    tick(4);
    ev = 1'b0;
    tick(4);
    gate = 1'b0;
    tick(2);
    chk("t6_first", 32'(first), 32'd5);
    chk("t6_cnt",   32'(cnt),   32'd1);
    tick(3);
    gate = 1'b1;
    tick(8);
    gate = 1'b0;
    tick(2);
    chk("t6_none", 32'(first), 32'hFFFF);
    chk("t6_cnt0", 32'(cnt),   32'd0);
    tick(3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
